// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Groups the two requester ports and the data-memory port of dmem_arbiter.
//
// Signals
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester commands
//   gnt0/gnt1   : one-cycle pulse, command captured
//   ack0/ack1   : one-cycle pulse, transaction complete
//   rdata0/rdata1 : read data, valid with ackN on a read
//   busy        : arbiter is not idle
//   mem_address, mem_write_data, mem_read, mem_write : registered memory command
//   mem_read_data : memory read port, updated on the edge that samples mem_read
//   err0/err1   : misaligned / out-of-range flag, pulsed with ackN
//                 (present only when DMEM_ARB_ALIGN_CHECK_EN is defined)
//
// Modports
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        err0;
  logic        err1;
`endif

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy,
           mem_address, mem_write_data, mem_read, mem_write
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  , output err0, err1
`endif
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy,
           mem_address, mem_write_data, mem_read, mem_write
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  , input err0, err1
`endif
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter in front of a single-port data memory. Requester 0 is
// the CPU, requester 1 a DMA/debug port. One transaction is in flight at a
// time: IDLE (sample + capture) -> ISSUE (grant + memory command) ->
// RESP (capture read data) -> IDLE (ack). Simultaneous requests alternate.
//
// Parameters
//   MEM_BYTES : byte size of the attached memory (used by the range check)
//
// Ports
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dmem_arbiter_if.slave, requester and memory signals
//
// Optional feature
//   DMEM_ARB_ALIGN_CHECK_EN : when defined, requests with addr[1:0]!=0 or
//   addr>MEM_BYTES-4 are granted and acked as usual but never reach the
//   memory, and err0/err1 pulse together with the ack.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        bad_q, bad_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
`endif

  logic        pick1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  // A memory smaller than one word, or not word-sized, cannot be addressed.
  if (MEM_BYTES < 4 || (MEM_BYTES % 4) != 0) begin : g_mem_bytes_check
    $error("dmem_arbiter: MEM_BYTES must be a non-zero multiple of 4");
  end

  // Requester 1 wins when it is alone, or on a tie when requester 0 was
  // granted last. last_grant resets to 1 so requester 0 takes the first tie.
  assign pick1     = bus.req1 & (~bus.req0 | ~last_grant_q);
  assign sel_we    = pick1 ? bus.we1    : bus.we0;
  assign sel_addr  = pick1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  assign sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
`else
  assign sel_bad = 1'b0;
`endif

  // Next-state and registered-output logic. Every output is a flop, so the
  // pulses for a phase are prepared in the preceding state.
  always_comb begin
    state_d          = state_q;
    win_d            = win_q;
    we_d             = we_q;
    bad_d            = bad_q;
    last_grant_d     = last_grant_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    rdata0_d         = rdata0_q;
    rdata1_d         = rdata1_q;
    gnt0_d           = 1'b0;
    gnt1_d           = 1'b0;
    ack0_d           = 1'b0;
    ack1_d           = 1'b0;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    err0_d           = 1'b0;
    err1_d           = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d          = ISSUE;
          win_d            = pick1;
          we_d             = sel_we;
          bad_d            = sel_bad;
          mem_address_d    = sel_addr;
          mem_write_data_d = sel_wdata;
          gnt0_d           = ~pick1;
          gnt1_d           = pick1;
          // A rejected request still gets its grant but no memory command.
          mem_read_d       = ~sel_we & ~sel_bad;
          mem_write_d      = sel_we & ~sel_bad;
        end
      end
      ISSUE: begin
        // The grant is visible this cycle, so the pointer moves now.
        state_d      = RESP;
        last_grant_d = win_q;
      end
      RESP: begin
        state_d = IDLE;
        if (!we_q && !bad_q) begin
          if (win_q) begin
            rdata1_d = bus.mem_read_data;
          end else begin
            rdata0_d = bus.mem_read_data;
          end
        end
        ack0_d = ~win_q;
        ack1_d = win_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        err0_d = bad_q & ~win_q;
        err1_d = bad_q & win_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      win_q            <= 1'b0;
      we_q             <= 1'b0;
      bad_q            <= 1'b0;
      last_grant_q     <= 1'b1;
      gnt0_q           <= 1'b0;
      gnt1_q           <= 1'b0;
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= 32'h0;
      mem_write_data_q <= 32'h0;
      rdata0_q         <= 32'h0;
      rdata1_q         <= 32'h0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err0_q           <= 1'b0;
      err1_q           <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      win_q            <= win_d;
      we_q             <= we_d;
      bad_q            <= bad_d;
      last_grant_q     <= last_grant_d;
      gnt0_q           <= gnt0_d;
      gnt1_q           <= gnt1_d;
      ack0_q           <= ack0_d;
      ack1_q           <= ack1_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      rdata0_q         <= rdata0_d;
      rdata1_q         <= rdata1_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err0_q           <= err0_d;
      err1_q           <= err1_d;
`endif
    end
  end

  assign bus.gnt0           = gnt0_q;
  assign bus.gnt1           = gnt1_q;
  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign bus.err0           = err0_q;
  assign bus.err1           = err1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Testbench for dmem_arbiter. A behavioural 1 KiB memory sits on the memory
// port; word i initially holds bytes {4i+3, 4i+2, 4i+1, 4i}. Each transaction
// pushes its expected grant and ack (requester, cycle, read data, error) into
// scoreboard queues; a negedge monitor pops and compares them as the DUT
// produces grants and acks. Scenario tasks add their own direct checks.
// DMEM_ARB_ALIGN_CHECK_EN enables the alignment / range scenario.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int          WORDS     = MEM_BYTES / 4;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        gntq[$];
  exp_t        ackq[$];
  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] tb_rdata[2];

  dmem_arbiter_if bus();

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears on the edge that samples mem_read.
  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_address[9:2]];
    if (bus.mem_write) mem[bus.mem_address[9:2]] = bus.mem_write_data;
  end

  // Scoreboard monitor and one-hot invariants, sampled at the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] obs_rdata;
    bit          obs_err;
    if (!rst) begin
      checks++;
      if ((bus.gnt0 && bus.gnt1) || (bus.ack0 && bus.ack1) || (bus.mem_read && bus.mem_write)) begin
        errors++;
        $display("[TB] FAIL exclusive cyc=%0d gnt=%b%b ack=%b%b rd/wr=%b%b, required at most one high in each pair",
                 cyc, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.mem_read, bus.mem_write);
      end
      if (bus.gnt0 || bus.gnt1) begin
        checks++;
        if (gntq.size() == 0) begin
          errors++;
          $display("[TB] FAIL grant cyc=%0d got unexpected gnt%0d, required none", cyc, bus.gnt1);
        end else begin
          e = gntq.pop_front();
          if (bus.gnt1 !== e.id || cyc !== e.cyc) begin
            errors++;
            $display("[TB] FAIL grant got gnt%0d at cyc %0d, required gnt%0d at cyc %0d", bus.gnt1, cyc, e.id, e.cyc);
          end
        end
      end
      if (bus.ack0 || bus.ack1) begin
        checks++;
        obs_rdata = bus.ack1 ? bus.rdata1 : bus.rdata0;
        obs_err   = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        obs_err   = bus.ack1 ? bus.err1 : bus.err0;
`endif
        if (ackq.size() == 0) begin
          errors++;
          $display("[TB] FAIL ack cyc=%0d got unexpected ack%0d, required none", cyc, bus.ack1);
        end else begin
          e = ackq.pop_front();
          if (bus.ack1 !== e.id || cyc !== e.cyc || obs_rdata !== e.rdata || obs_err !== e.err) begin
            errors++;
            $display("[TB] FAIL ack got id=%0d cyc=%0d rdata=%h err=%0d, required id=%0d cyc=%0d rdata=%h err=%0d",
                     bus.ack1, cyc, obs_rdata, obs_err, e.id, e.cyc, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (id) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  // Reference model for one transaction sampled in IDLE at cycle 'sample'.
  task automatic push_exp(input bit id, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input int sample);
    exp_t e;
    bit   bad;
    bad = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    bad = (a[1:0] != 2'b00) || (a > 32'(MEM_BYTES - 4));
`endif
    if (!bad && we) ref_mem[a[9:2]] = d;
    else if (!bad) tb_rdata[id] = ref_mem[a[9:2]];
    e.id = id; e.rdata = tb_rdata[id]; e.err = bad;
    e.cyc = sample + 1;
    gntq.push_back(e);
    e.cyc = sample + 3;
    ackq.push_back(e);
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tb_rdata[0] = 32'h0; tb_rdata[1] = 32'h0;
    tick();
    tick();
    flags = {bus.busy, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.mem_read, bus.mem_write};
    checks++;
    if (flags !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got busy/gnt/ack/rd/wr=%b, required 0000000", flags);
    end
    checks++;
    if (bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_bus got addr=%h wdata=%h, required 0/0", bus.mem_address, bus.mem_write_data);
    end
    checks++;
    if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata got %h/%h, required 0/0", bus.rdata0, bus.rdata1);
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    int s;
    drive_req(1'b0, 1'b0, 32'h10, 32'h0);
    s = cyc;
    push_exp(1'b0, 1'b0, 32'h10, 32'h0, s);
    tick();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_address !== 32'h10) begin
      errors++;
      $display("[TB] FAIL read_issue got rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=00000010",
               bus.mem_read, bus.mem_write, bus.mem_address);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_busy got %b, required 1", bus.busy);
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.mem_read !== 1'b0 || bus.ack0 !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_resp got rd=%b ack0=%b busy=%b, required 0/0/1", bus.mem_read, bus.ack0, bus.busy);
    end
    for (int i = 0; i < 20 && ackq.size() != 0; i++) tick();
    checks++;
    if (ackq.size() != 0) begin
      errors++;
      $display("[TB] FAIL read_timeout got %0d pending acks, required 0", ackq.size());
      ackq.delete(); gntq.delete();
    end
    tick();
    tick();
    checks++;
    if (bus.rdata0 !== 32'h13121110 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_hold got rdata0=%h busy=%b, required 13121110/0", bus.rdata0, bus.busy);
    end
  endtask

  task automatic test_write_read();
    drive_req(1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    push_exp(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, cyc);
    tick();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 ||
        bus.mem_address !== 32'h20 || bus.mem_write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_issue got wr=%b rd=%b addr=%h data=%h, required 1/0/00000020/deadbeef",
               bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_write_data);
    end
    bus.req1 = 1'b0;
    tick();
    checks++;
    if (bus.mem_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_pulse got wr=%b after ISSUE, required 0", bus.mem_write);
    end
    for (int i = 0; i < 20 && ackq.size() != 0; i++) tick();
    // Read back on the ack cycle, followed immediately by a boundary read.
    drive_req(1'b1, 1'b0, 32'h20, 32'h0);
    push_exp(1'b1, 1'b0, 32'h20, 32'h0, cyc);
    tick();
    bus.req1 = 1'b0;
    for (int i = 0; i < 20 && ackq.size() != 0; i++) tick();
    drive_req(1'b0, 1'b0, 32'h3FC, 32'h0);
    push_exp(1'b0, 1'b0, 32'h3FC, 32'h0, cyc);
    tick();
    bus.req0 = 1'b0;
    for (int i = 0; i < 20 && ackq.size() != 0; i++) tick();
    checks++;
    if (ackq.size() != 0) begin
      errors++;
      $display("[TB] FAIL write_read_timeout got %0d pending acks, required 0", ackq.size());
      ackq.delete(); gntq.delete();
    end
    checks++;
    if (bus.rdata1 !== 32'hDEADBEEF || bus.rdata0 !== 32'hFFFEFDFC) begin
      errors++;
      $display("[TB] FAIL write_read_data got rdata1=%h rdata0=%h, required deadbeef/fffefdfc",
               bus.rdata1, bus.rdata0);
    end
  endtask

  task automatic test_contention();
    int s;
    int n;
    rst = 1'b1;
    tb_rdata[0] = 32'h0; tb_rdata[1] = 32'h0;
    drive_req(1'b0, 1'b0, 32'h40, 32'h0);
    drive_req(1'b1, 1'b0, 32'h80, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    s = cyc;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, s);
    push_exp(1'b1, 1'b0, 32'h80, 32'h0, s + 3);
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, s + 6);
    push_exp(1'b1, 1'b0, 32'h80, 32'h0, s + 9);
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      tick();
      if (bus.gnt0 || bus.gnt1) begin
        n++;
        if (n == 3) bus.req0 = 1'b0;
        if (n == 4) bus.req1 = 1'b0;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL contention_grants got %0d grants, required 4", n);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
    end
    for (int i = 0; i < 20 && ackq.size() != 0; i++) tick();
    checks++;
    if (ackq.size() != 0) begin
      errors++;
      $display("[TB] FAIL contention_timeout got %0d pending acks, required 0", ackq.size());
      ackq.delete(); gntq.delete();
    end
  endtask

  task automatic test_reset_mid_op();
    int   s;
    exp_t g;
    tick();
    drive_req(1'b0, 1'b0, 32'h44, 32'h0);
    s = cyc;
    g.id = 1'b0; g.rdata = 32'h0; g.err = 1'b0; g.cyc = s + 1;
    gntq.push_back(g);
    tick();
    bus.req0 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.mem_read !== 1'b0 || bus.rdata0 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid got busy=%b ack0=%b rd=%b rdata0=%h, required 0/0/0/0",
               bus.busy, bus.ack0, bus.mem_read, bus.rdata0);
    end
    tb_rdata[0] = 32'h0; tb_rdata[1] = 32'h0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++;
    if (gntq.size() != 0 || ackq.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_queue got %0d grants/%0d acks outstanding, required 0/0",
               gntq.size(), ackq.size());
      gntq.delete(); ackq.delete();
    end
  endtask

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  task automatic test_align_check();
    logic [31:0] a_list[3];
    a_list[0] = 32'h13;
    a_list[1] = 32'h3FC;
    a_list[2] = 32'h3FD;
    for (int k = 0; k < 3; k++) begin
      drive_req(1'b0, 1'b0, a_list[k], 32'h0);
      push_exp(1'b0, 1'b0, a_list[k], 32'h0, cyc);
      tick();
      checks++;
      if (bus.mem_read !== (k == 1)) begin
        errors++;
        $display("[TB] FAIL align_issue addr=%h got rd=%b, required %0d", a_list[k], bus.mem_read, (k == 1));
      end
      bus.req0 = 1'b0;
      for (int i = 0; i < 20 && ackq.size() != 0; i++) tick();
    end
    checks++;
    if (ackq.size() != 0 || bus.rdata0 !== 32'hFFFEFDFC) begin
      errors++;
      $display("[TB] FAIL align_final got %0d pending, rdata0=%h, required 0/fffefdfc", ackq.size(), bus.rdata0);
      ackq.delete(); gntq.delete();
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      ref_mem[i] = mem[i];
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0;
    bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_reset_mid_op();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    test_align_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog got no completion by 20000 time units, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 1024, byte size of the attached data memory.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req0, req1  in  1 each  access request, requester 0 (CPU) and requester 1 (DMA/debug).
REQ-005 we0, we1  in  1 each  1 = write, 0 = read; valid while reqN high.
REQ-006 addr0, addr1  in  32 each  byte address.
REQ-007 wdata0, wdata1  in  32 each  write data.
REQ-008 gnt0, gnt1  out  1 each  one-cycle pulse: request accepted, command captured.
REQ-009 ack0, ack1  out  1 each  one-cycle pulse: transaction complete.
REQ-010 rdata0, rdata1  out  32 each  read data, valid when ackN high for a read.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 mem_address  out  32; mem_write_data  out  32; mem_read  out  1; mem_write  out  1; all registered.
REQ-013 mem_read_data  in  32  memory read port, updated by the memory on the clock edge that samples mem_read.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, RESP; IDLE->ISSUE on any reqN high, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-015 In IDLE at cycle N with a request present, the arbiter SHALL register winner, we, addr and wdata, and in cycle N+1 (ISSUE) SHALL drive gntW=1 and exactly one of mem_read/mem_write=1 for that single cycle.
REQ-016 In RESP (cycle N+2) the arbiter SHALL register mem_read_data into rdataW for reads, and in cycle N+3 SHALL pulse ackW=1; rdataW holds until the next read by the same requester.
REQ-017 Latency: request sampled N -> gnt N+1 -> ack N+3; one transaction per 3 cycles maximum.
REQ-018 Only one requester is served at a time; a request arriving while busy SHALL wait, held level, until sampled in IDLE.
REQ-019 A requester SHALL hold req/we/addr/wdata stable until gnt; req still high in the IDLE cycle after ack is a new request.
REQ-020 Single request: grant it; both requests in the same IDLE cycle: grant the requester not granted last (round-robin).
REQ-021 Priority pointer last_grant SHALL update only on a grant.
REQ-022 Writes SHALL send all 32 bits of wdata; the arbiter never modifies address or data.
REQ-023 mem_read and mem_write SHALL never be high simultaneously and SHALL be 0 outside ISSUE.
REQ-024 At most one of gnt0/gnt1 and at most one of ack0/ack1 SHALL be high in any cycle.

Reset
REQ-025 rst high SHALL immediately force state IDLE, all gnt/ack/mem_read/mem_write/busy to 0, mem_address/mem_write_data/rdata0/rdata1 to 0, last_grant to 1 (requester 0 wins the first tie).
REQ-026 A transaction interrupted by reset SHALL produce no ack; after release the requester must re-request.

Configuration
REQ-027 With DMEM_ARB_ALIGN_CHECK_EN defined, a request with addr[1:0]!=0 or addr>MEM_BYTES-4 SHALL still be granted at N+1 with mem_read/mem_write kept 0, and SHALL ack at N+3 with rdata unchanged plus outputs err0/err1 (1 bit each) pulsed alongside ack.
REQ-028 Without DMEM_ARB_ALIGN_CHECK_EN, no check is made, err0/err1 ports do not exist, and every request reaches the memory.

Verification
REQ-029 Read: req0=1, we0=0, addr0=0x10 at cycle 0, memory holding 0x13121110 -> gnt0 cycle 1 with mem_read=1, mem_address=0x10; ack0 cycle 3, rdata0=0x13121110.
REQ-030 Write then read: req1 write addr1=0x20, wdata1=0xDEADBEEF; then req1 read 0x20 -> mem_write pulse in write ISSUE; later read acks rdata1=0xDEADBEEF.
REQ-031 Contention: req0 and req1 both held high from reset release -> grants alternate 0,1,0,1 at 3-cycle spacing, no cycle with both gnts.
REQ-032 Reset mid-op: assert rst during RESP of a read -> mem_read/ack stay 0, no ack0 after release, busy=0 immediately.
REQ-033 With DMEM_ARB_ALIGN_CHECK_EN: req0 read addr0=0x13 -> gnt0 cycle 1, mem_read stays 0, ack0 and err0 cycle 3; addr0=0x3FC reads normally, addr0=0x3FD errors.
